nco_channel_scheduler: RTL and testbench

// - Time-multiplexes one sin/cos LUT (sin_cos_generator: 2-stage, advances only on irx_valid, orx_ready = itx_ready) among NOF_CH NCO channels.
// - Holds a phase accumulator, an increment and an enable per channel, and issues one phase per slot in round-robin order.
// - Tags each issue with its channel. Returns {cos,sin} samples to a downstream mixer bank with a channel id and valid/ready.

---
 rtl/nco_channel_scheduler_pkg.sv | 18 +
 rtl/nco_channel_scheduler_if.sv | 37 +++
 rtl/nco_channel_scheduler_acc.sv | 68 ++++++
 rtl/nco_channel_scheduler.sv | 114 +++++++++++
 tb/tb_nco_channel_scheduler.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/nco_channel_scheduler_pkg.sv
// Shared types and constants for the NCO channel scheduler.
package nco_channel_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  // Number of tag-free issues needed to push the last real sample out of the LUT.
  localparam int unsigned FLUSH_ISSUES = 2;

  // Round-robin successor of v among n slots.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/nco_channel_scheduler_if.sv
// Control, LUT-side and downstream-side signals of the NCO channel scheduler.
interface nco_channel_scheduler_if #(
  parameter int unsigned CH_W     = 2,
  parameter int unsigned ACC_W    = 24,
  parameter int unsigned PHASE_W  = 12,
  parameter int unsigned SINCOS_W = 16
);
  logic                  irun;
  logic                  isync;
  logic                  icfg_valid;
  logic [CH_W-1:0]       icfg_chan;
  logic [ACC_W-1:0]      icfg_inc;
  logic                  icfg_en;
  logic                  osc_valid;
  logic [PHASE_W-1:0]    osc_phase;
  logic                  isc_ready;
  logic [2*SINCOS_W-1:0] isc_data;
  logic                  itx_ready;
  logic                  otx_valid;
  logic [CH_W-1:0]       otx_chan;
  logic [2*SINCOS_W-1:0] otx_data;
  logic                  obusy;

  // Scheduler side.
  modport master (
    input  irun, isync, icfg_valid, icfg_chan, icfg_inc, icfg_en,
    input  isc_ready, isc_data, itx_ready,
    output osc_valid, osc_phase, otx_valid, otx_chan, otx_data, obusy
  );

  // Environment side: control source, LUT and downstream mixer bank.
  modport slave (
    output irun, isync, icfg_valid, icfg_chan, icfg_inc, icfg_en,
    output isc_ready, isc_data, itx_ready,
    input  osc_valid, osc_phase, otx_valid, otx_chan, otx_data, obusy
  );
endinterface

// File: rtl/nco_channel_scheduler_acc.sv
// Per-channel phase accumulator, increment and enable registers.
module nco_phase_acc_bank #(
  parameter int unsigned NOF_CH  = 4,
  parameter int unsigned CH_W    = 2,
  parameter int unsigned ACC_W   = 24,
  parameter int unsigned PHASE_W = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sync,
  input  logic               cfg_valid,
  input  logic [CH_W-1:0]    cfg_chan,
  input  logic [ACC_W-1:0]   cfg_inc,
  input  logic               cfg_en,
  input  logic [CH_W-1:0]    ptr,
  input  logic               step,
  output logic [PHASE_W-1:0] phase,
  output logic               en
);

  logic [ACC_W-1:0] acc   [NOF_CH];
  logic [ACC_W-1:0] inc   [NOF_CH];
  logic             en_r  [NOF_CH];

  // Accumulate the slot being issued; sync overrides the same-edge accumulate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NOF_CH; i++) acc[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NOF_CH; i++) begin
        if (sync)
          acc[i] <= '0;
        else if (step && ptr == CH_W'(i))
          acc[i] <= acc[i] + inc[i];
      end
    end
  end

  // Config write port; the issuing slot already read the old values this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NOF_CH; i++) begin
        inc[i]  <= '0;
        en_r[i] <= 1'b0;
      end
    end else if (cfg_valid) begin
      for (int unsigned i = 0; i < NOF_CH; i++) begin
        if (cfg_chan == CH_W'(i)) begin
          inc[i]  <= cfg_inc;
          en_r[i] <= cfg_en;
        end
      end
    end
  end

  // Read port indexed by ptr (mux form keeps non-power-of-2 NOF_CH in range).
  always_comb begin
    phase = '0;
    en    = 1'b0;
    for (int unsigned i = 0; i < NOF_CH; i++) begin
      if (ptr == CH_W'(i)) begin
        phase = acc[i][ACC_W-1 -: PHASE_W];
        en    = en_r[i];
      end
    end
  end

endmodule

// File: rtl/nco_channel_scheduler.sv
// Round-robin scheduler sharing one 2-stage sin/cos LUT among NOF_CH NCO channels.
module nco_channel_scheduler
  import nco_channel_scheduler_pkg::*;
#(
  parameter int unsigned NOF_CH   = 4,
  parameter int unsigned CH_W     = 2,
  parameter int unsigned ACC_W    = 24,
  parameter int unsigned PHASE_W  = 12,
  parameter int unsigned SINCOS_W = 16
) (
  input logic                    iclk,
  input logic                    iresetn,
  nco_channel_scheduler_if.master bus
);

  typedef struct packed {
    logic            en;
    logic [CH_W-1:0] chan;
  } tag_t;

  state_t                state;
  state_t                state_nxt;
  logic [CH_W-1:0]       ptr;
  tag_t                  t1;
  tag_t                  t2;
  tag_t                  tag_now;
  logic [1:0]            flush_cnt;
  logic                  issue;
  logic                  run_issue;
  logic [PHASE_W-1:0]    acc_phase;
  logic                  acc_en;
  logic [2*SINCOS_W-1:0] sample;

  assign issue     = (state != IDLE) && bus.isc_ready;
  assign run_issue = issue && (state == RUN);
  assign sample    = bus.isc_data;

  nco_phase_acc_bank #(
    .NOF_CH  (NOF_CH),
    .CH_W    (CH_W),
    .ACC_W   (ACC_W),
    .PHASE_W (PHASE_W)
  ) u_acc (
    .clk       (iclk),
    .rst_n     (iresetn),
    .sync      (bus.isync),
    .cfg_valid (bus.icfg_valid),
    .cfg_chan  (bus.icfg_chan),
    .cfg_inc   (bus.icfg_inc),
    .cfg_en    (bus.icfg_en),
    .ptr       (ptr),
    .step      (run_issue),
    .phase     (acc_phase),
    .en        (acc_en)
  );

  // State register.
  always_ff @(posedge iclk or negedge iresetn) begin
    if (!iresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state: a flush always runs to completion before honouring irun again.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (bus.irun) state_nxt = RUN;
      RUN:   if (!bus.irun) state_nxt = FLUSH;
      FLUSH: begin
        if ((issue && flush_cnt == 2'(FLUSH_ISSUES - 1)) || (!t1.en && !t2.en))
          state_nxt = bus.irun ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Tag for the current slot; flush slots carry no sample.
  always_comb begin
    tag_now = '0;
    if (state == RUN) begin
      tag_now.en   = acc_en;
      tag_now.chan = ptr;
    end
  end

  // Slot pointer, tag pipe (advances in lockstep with the LUT) and flush counter.
  always_ff @(posedge iclk or negedge iresetn) begin
    if (!iresetn) begin
      ptr       <= '0;
      t1        <= '0;
      t2        <= '0;
      flush_cnt <= '0;
    end else begin
      if (run_issue) ptr <= CH_W'(wrap_inc(int'(ptr), NOF_CH));
      if (issue) begin
        t1 <= tag_now;
        t2 <= t1;
      end
      if (state != FLUSH) flush_cnt <= '0;
      else if (issue)     flush_cnt <= flush_cnt + 2'd1;
    end
  end

  // Outputs.
  always_comb begin
    bus.osc_valid = issue;
    bus.osc_phase = (state == RUN) ? acc_phase : '0;
    bus.otx_valid = t2.en;
    bus.otx_chan  = t2.chan;
    bus.otx_data  = sample;
    bus.obusy     = (state != IDLE);
  end

endmodule

// File: tb/tb_nco_channel_scheduler.sv
// Randomized scoreboard bench for nco_channel_scheduler with a behavioural LUT.
module tb_nco_channel_scheduler;

  localparam int unsigned NOF_CH = 4;

  logic iclk = 1'b0;
  logic iresetn;

  always #5 iclk = ~iclk;

  nco_channel_scheduler_if #(.CH_W(2), .ACC_W(16), .PHASE_W(12), .SINCOS_W(16)) bus ();

  nco_channel_scheduler #(
    .NOF_CH(4), .CH_W(2), .ACC_W(16), .PHASE_W(12), .SINCOS_W(16)
  ) dut (
    .iclk    (iclk),
    .iresetn (iresetn),
    .bus     (bus)
  );

  // Golden LUT contents: an arbitrary injective map of phase to {cos,sin}.
  function automatic logic [31:0] lut(input logic [11:0] p);
    logic [15:0] s;
    logic [15:0] c;
    s = {p, 4'h0} ^ 16'h3C5A;
    c = {4'h9, ~p} + 16'h0123;
    return {c, s};
  endfunction

  // Behavioural two-stage LUT that advances only when fed.
  logic [31:0] lut_s1, lut_s2;
  always_ff @(posedge iclk or negedge iresetn) begin
    if (!iresetn) begin
      lut_s1 <= '0;
      lut_s2 <= '0;
    end else if (bus.osc_valid) begin
      lut_s1 <= lut(bus.osc_phase);
      lut_s2 <= lut_s1;
    end
  end
  assign bus.isc_data  = lut_s2;
  assign bus.isc_ready = bus.itx_ready;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [1:0]  chan;
    logic [31:0] data;
  } smp_t;
  smp_t exp_q[$];

  int unsigned m_mode;   // 0 idle, 1 running, 2 draining
  int unsigned m_ptr;
  int unsigned m_fcnt;
  logic [15:0] m_acc[NOF_CH];
  logic [15:0] m_inc[NOF_CH];
  logic        m_en [NOF_CH];
  bit          m_h0, m_h1; // enable flags of the two most recent issues

  always @(negedge iclk) begin
    bit exp_v;
    bit quiet;
    bit en_now;
    logic [11:0] ph;
    smp_t s;
    if (!iresetn) begin
      m_mode = 0; m_ptr = 0; m_fcnt = 0; m_h0 = 0; m_h1 = 0;
      for (int i = 0; i < NOF_CH; i++) begin
        m_acc[i] = '0; m_inc[i] = '0; m_en[i] = 1'b0;
      end
      exp_q.delete();
    end else begin
      exp_v = (m_mode != 0) && bus.itx_ready;
      quiet = !m_h0 && !m_h1;
      ph    = (m_mode == 1) ? m_acc[m_ptr][15:4] : 12'h000;
      chk("osc_valid", 64'(bus.osc_valid), 64'(exp_v));
      if (exp_v) chk("osc_phase", 64'(bus.osc_phase), 64'(ph));
      chk("obusy", 64'(bus.obusy), 64'(m_mode != 0));
      if (exp_v) begin
        if (m_mode == 1) begin
          en_now = m_en[m_ptr];
          if (en_now) begin
            s.chan = 2'(m_ptr);
            s.data = lut(ph);
            exp_q.push_back(s);
          end
          m_h1 = m_h0; m_h0 = en_now;
          m_acc[m_ptr] = m_acc[m_ptr] + m_inc[m_ptr];
          m_ptr = (m_ptr + 1) % NOF_CH;
        end else begin
          m_h1 = m_h0; m_h0 = 1'b0;
          m_fcnt++;
        end
      end
      if (bus.isync) for (int i = 0; i < NOF_CH; i++) m_acc[i] = '0;
      if (bus.icfg_valid) begin
        m_inc[bus.icfg_chan] = bus.icfg_inc;
        m_en[bus.icfg_chan]  = bus.icfg_en;
      end
      case (m_mode)
        0: if (bus.irun) m_mode = 1;
        1: if (!bus.irun) begin m_mode = 2; m_fcnt = 0; end
        default: if (m_fcnt >= 2 || quiet) m_mode = bus.irun ? 1 : 0;
      endcase
    end
  end

  // ---------------- output monitor ----------------
  bit          held;
  logic [1:0]  h_chan;
  logic [31:0] h_data;

  always @(negedge iclk) begin
    smp_t e;
    if (!iresetn) begin
      held = 0;
    end else begin
      if (held) begin
        chk("hold_valid", 64'(bus.otx_valid), 64'd1);
        chk("hold_chan", 64'(bus.otx_chan), 64'(h_chan));
        chk("hold_data", 64'(bus.otx_data), 64'(h_data));
      end
      if (bus.otx_valid && bus.itx_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_sample: got chan %0d data %h expected none", bus.otx_chan, bus.otx_data);
        end else begin
          e = exp_q.pop_front();
          chk("otx_chan", 64'(bus.otx_chan), 64'(e.chan));
          chk("otx_data", 64'(bus.otx_data), 64'(e.data));
        end
      end
      held   = bus.otx_valid && !bus.itx_ready;
      h_chan = bus.otx_chan;
      h_data = bus.otx_data;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge iclk);
    #1;
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [15:0] inc, input logic en);
    bus.icfg_valid = 1'b1; bus.icfg_chan = ch; bus.icfg_inc = inc; bus.icfg_en = en;
    step(1);
    bus.icfg_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (bus.obusy && n < 60) begin
      step(1);
      n++;
    end
    chk({nm, "_idle"}, 64'(bus.obusy), 64'd0);
    chk({nm, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    iresetn = 1'b0;
    bus.irun = 0; bus.isync = 0; bus.icfg_valid = 0; bus.icfg_chan = '0;
    bus.icfg_inc = '0; bus.icfg_en = 0; bus.itx_ready = 0;
    step(3);
    chk("rst_osc_valid", 64'(bus.osc_valid), 64'd0);
    chk("rst_osc_phase", 64'(bus.osc_phase), 64'd0);
    chk("rst_otx_valid", 64'(bus.otx_valid), 64'd0);
    chk("rst_otx_chan", 64'(bus.otx_chan), 64'd0);
    chk("rst_otx_data", 64'(bus.otx_data), 64'd0);
    chk("rst_obusy", 64'(bus.obusy), 64'd0);
    iresetn = 1'b1;
    bus.itx_ready = 1'b1;
    step(10);

    // Single channel.
    cfg(2'd0, 16'h0100, 1'b1);
    bus.irun = 1'b1;
    step(40);

    // All channels, ch1 wraps downward.
    cfg(2'd1, 16'hFFFF, 1'b1);
    cfg(2'd2, 16'($urandom), 1'b1);
    cfg(2'd3, 16'($urandom), 1'b1);
    step(40);

    // Downstream stall.
    bus.itx_ready = 1'b0;
    step(5);
    bus.itx_ready = 1'b1;
    step(20);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      bus.itx_ready  = ($urandom_range(9) < 7);
      bus.icfg_valid = ($urandom_range(7) == 0);
      bus.icfg_chan  = 2'($urandom);
      bus.icfg_inc   = 16'($urandom);
      bus.icfg_en    = ($urandom_range(3) != 0);
      bus.isync      = ($urandom_range(39) == 0);
      if ($urandom_range(29) == 0) bus.irun = ~bus.irun;
      step(1);
    end
    bus.icfg_valid = 0; bus.isync = 0; bus.itx_ready = 1'b1;

    // Clean drain to idle.
    for (int c = 0; c < NOF_CH; c++) cfg(2'(c), 16'(16'h0111 * (c + 1)), 1'b1);
    bus.irun = 1'b1;
    step(10);
    bus.irun = 1'b0;
    wait_idle("flush");

    // irun reasserted during a flush.
    bus.irun = 1'b1;
    step(12);
    bus.irun = 1'b0;
    step(1);
    bus.irun = 1'b1;
    step(10);
    chk("reflush_busy", 64'(bus.obusy), 64'd1);

    // isync with a same-cycle config write to the channel about to issue.
    bus.isync = 1'b1;
    bus.icfg_valid = 1'b1; bus.icfg_chan = 2'(m_ptr); bus.icfg_inc = 16'h0300; bus.icfg_en = 1'b1;
    step(1);
    bus.isync = 1'b0; bus.icfg_valid = 1'b0;
    step(20);

    // Asynchronous reset mid-run.
    #2 iresetn = 1'b0;
    #1;
    chk("arst_otx_valid", 64'(bus.otx_valid), 64'd0);
    chk("arst_osc_valid", 64'(bus.osc_valid), 64'd0);
    chk("arst_obusy", 64'(bus.obusy), 64'd0);
    step(2);
    iresetn = 1'b1;
    step(1);

    cfg(2'd2, 16'h0040, 1'b1);
    bus.irun = 1'b1;
    step(30);
    bus.irun = 1'b0;
    wait_idle("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
